atan_share_arbiter: RTL and testbench

ATAN_SHARE_ARBITER -- requirements
Module: atan_share_arbiter

---
 rtl/atan_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_atan_share_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/atan_share_arbiter.sv
// atan_share_arbiter
//
// Shares one gradient-direction (atan) unit among NUM_REQ requesters.
// A round-robin arbiter accepts at most one gx/gy pair per cycle and
// registers it onto the unit operand bus. A tag (valid + requester index)
// follows the operands through a 1+LAT stage shift pipeline. When the tag
// reaches the tail, the unit's direction code is steered back to the
// requester that issued the operands.
//
// Optional build macro:
//   ATAN_ARB_STATS_EN - adds o_grant_cnt, which holds per-requester
//                       saturating 16-bit transfer counters.
//
// Ports:
//   i_clk, i_rst_n : rising-edge clock, asynchronous active-low reset
//   i_req_valid    : per-requester request valid
//   i_req_gx/gy    : packed signed gradients, requester k in slice k
//   o_req_ready    : one-hot-or-zero grant (combinational)
//   o_gx/o_gy      : registered operands to the shared direction unit
//   i_direction    : direction code returned by the unit, LAT cycles later
//   o_rsp_valid    : one-hot-or-zero response strobe
//   o_rsp_dir      : direction for the strobed requester, else 2'b00
//   o_busy         : high while any accepted request is in flight
//   o_grant_cnt    : (ATAN_ARB_STATS_EN only) per-requester counters
module atan_share_arbiter #(
    parameter int NBIT_SOBEL = 11,
    parameter int NUM_REQ    = 4,
    parameter int LAT        = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ*NBIT_SOBEL-1:0]    i_req_gx,
    input  logic [NUM_REQ*NBIT_SOBEL-1:0]    i_req_gy,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic signed [NBIT_SOBEL-1:0]     o_gx,
    output logic signed [NBIT_SOBEL-1:0]     o_gy,
    input  logic [1:0]                       i_direction,
    output logic [NUM_REQ-1:0]               o_rsp_valid,
    output logic [1:0]                       o_rsp_dir,
    output logic                             o_busy
`ifdef ATAN_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]            o_grant_cnt
`endif
);

    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 1 + LAT;

    logic [IW-1:0]    ptr;
    logic             grant_found;
    logic [IW-1:0]    grant_idx;
    logic             transfer;
    logic [DEPTH-1:0] tag_vld;
    logic [IW-1:0]    tag_idx [DEPTH];

    // Round-robin search. Start at ptr and scan in ascending index order,
    // wrapping at NUM_REQ. The first valid requester found wins.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && i_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    // Ready is gated by reset so that no handshake can complete while the
    // block is held in reset.
    always_comb begin
        transfer    = grant_found && i_rst_n;
        o_req_ready = '0;
        if (transfer) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    // Capture the operands of the winning requester and move the pointer
    // past the winner. With no transfer, the pointer and operands hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr  <= '0;
            o_gx <= '0;
            o_gy <= '0;
        end else if (transfer) begin
            o_gx <= i_req_gx[int'(grant_idx)*NBIT_SOBEL +: NBIT_SOBEL];
            o_gy <= i_req_gy[int'(grant_idx)*NBIT_SOBEL +: NBIT_SOBEL];
            ptr  <= (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // The tag pipeline advances every cycle. Stage 0 lines up with o_gx/o_gy,
    // and the tail lines up with the unit's direction output LAT cycles later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_vld <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            tag_vld    <= {tag_vld[DEPTH-2:0], transfer};
            tag_idx[0] <= grant_idx;
            for (int s = 1; s < DEPTH; s++) begin
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    // Steer the unit result to the requester named by the tail tag.
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_dir   = 2'b00;
        if (tag_vld[DEPTH-1]) begin
            o_rsp_valid[tag_idx[DEPTH-1]] = 1'b1;
            o_rsp_dir                     = i_direction;
        end
        o_busy = |tag_vld;
    end

`ifdef ATAN_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];

    // Per-requester transfer counters. Each counter sticks at 16'hFFFF
    // instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (transfer && grant_idx == IW'(k) && grant_cnt[k] != 16'hFFFF) begin
                    grant_cnt[k] <= grant_cnt[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        o_grant_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_grant_cnt[k*16 +: 16] = grant_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_atan_share_arbiter.sv
// tb_atan_share_arbiter
//
// Directed bench for atan_share_arbiter. It runs with default parameters:
// NUM_REQ=4, NBIT_SOBEL=11, LAT=1.
//
// A round-robin model predicts every grant. Each accepted request pushes its
// expected response onto a scoreboard queue, tagged with the cycle in which
// the response is due. A small behavioural direction unit closes the loop.
module tb_atan_share_arbiter;

    localparam int NB  = 11;
    localparam int N   = 4;
    localparam int LAT = 1;

    typedef struct {
        int         due;
        int         idx;
        logic [1:0] dir;
    } exp_t;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [N-1:0]    i_req_valid = '0;
    logic [N*NB-1:0] i_req_gx = '0;
    logic [N*NB-1:0] i_req_gy = '0;
    logic [N-1:0]    o_req_ready;
    logic [NB-1:0]   o_gx;
    logic [NB-1:0]   o_gy;
    logic [1:0]      i_direction;
    logic [N-1:0]    o_rsp_valid;
    logic [1:0]      o_rsp_dir;
    logic            o_busy;
`ifdef ATAN_ARB_STATS_EN
    logic [N*16-1:0] o_grant_cnt;
    int              m_cnt [N];
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            m_ptr = 0;
    logic [NB-1:0] exp_gx = '0;
    logic [NB-1:0] exp_gy = '0;
    exp_t          q [$];
    logic [1:0]    dpipe [LAT];
    logic [N*NB-1:0] gx_v;
    logic [N*NB-1:0] gy_v;

    always #5 i_clk = ~i_clk;

    atan_share_arbiter #(.NBIT_SOBEL(NB), .NUM_REQ(N), .LAT(LAT)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_gx    (i_req_gx),
        .i_req_gy    (i_req_gy),
        .o_req_ready (o_req_ready),
        .o_gx        (o_gx),
        .o_gy        (o_gy),
        .i_direction (i_direction),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_dir   (o_rsp_dir),
        .o_busy      (o_busy)
`ifdef ATAN_ARB_STATS_EN
        ,
        .o_grant_cnt (o_grant_cnt)
`endif
    );

    // Arbitrary but operand-dependent direction code for the stand-in unit.
    function automatic logic [1:0] dir_of(input logic [NB-1:0] gx, input logic [NB-1:0] gy);
        return {gx[0] ^ gy[NB-1], gy[0] ^ gx[NB-1]};
    endfunction

    // Behavioural direction unit with LAT cycles of latency.
    always @(posedge i_clk) begin
        dpipe[0] <= dir_of(o_gx, o_gy);
        for (int i = 1; i < LAT; i++) begin
            dpipe[i] <= dpipe[i-1];
        end
    end
    assign i_direction = dpipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle. Drive the inputs, check outputs at the negedge
    // against the model and scoreboard, advance the model, then step to
    // just after the next posedge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*NB-1:0] gx, input logic [N*NB-1:0] gy);
        logic [N-1:0] exp_ready;
        int           gi;
        bit           found;
        int           k;
        exp_t         e;
        i_req_valid = v;
        i_req_gx    = gx;
        i_req_gy    = gy;
        @(negedge i_clk);
        found = 1'b0;
        gi    = 0;
        for (int off = 0; off < N; off++) begin
            k = (m_ptr + off) % N;
            if (!found && v[k]) begin
                found = 1'b1;
                gi    = k;
            end
        end
        exp_ready = '0;
        if (found) exp_ready[gi] = 1'b1;
        checkOutput("req_ready", 64'(o_req_ready), 64'(exp_ready));
        checkOutput("busy", 64'(o_busy), 64'(q.size() != 0));
        checkOutput("o_gx", 64'(o_gx), 64'(exp_gx));
        checkOutput("o_gy", 64'(o_gy), 64'(exp_gy));
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            checkOutput("rsp_valid", 64'(o_rsp_valid), 64'(1) << e.idx);
            checkOutput("rsp_dir", 64'(o_rsp_dir), 64'(e.dir));
        end else begin
            checkOutput("rsp_valid_idle", 64'(o_rsp_valid), 64'(0));
            checkOutput("rsp_dir_idle", 64'(o_rsp_dir), 64'(0));
        end
        if (found) begin
            exp_gx = gx[gi*NB +: NB];
            exp_gy = gy[gi*NB +: NB];
            e.due  = cyc + 1 + LAT;
            e.idx  = gi;
            e.dir  = dir_of(exp_gx, exp_gy);
            q.push_back(e);
            m_ptr  = (gi + 1) % N;
`ifdef ATAN_ARB_STATS_EN
            if (m_cnt[gi] < 65535) m_cnt[gi]++;
`endif
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // Hold reset for one cycle with the given valids. Check that all
    // outputs are zero, then release just after a posedge.
    task automatic resetPulse(input logic [N-1:0] v);
        i_req_valid = v;
        i_rst_n     = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_ready", 64'(o_req_ready), 64'(0));
        checkOutput("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
        checkOutput("rst_rsp_dir", 64'(o_rsp_dir), 64'(0));
        checkOutput("rst_busy", 64'(o_busy), 64'(0));
        checkOutput("rst_gx", 64'(o_gx), 64'(0));
        checkOutput("rst_gy", 64'(o_gy), 64'(0));
`ifdef ATAN_ARB_STATS_EN
        checkOutput("rst_cnt", 64'(o_grant_cnt), 64'(0));
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        q.delete();
        m_ptr  = 0;
        exp_gx = '0;
        exp_gy = '0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        // Reset state, with every requester asking.
        resetPulse(4'b1111);

        // Single request from requester 0: gx=5, gy=-3.
        gx_v = '0;
        gy_v = '0;
        gx_v[0 +: NB] = NB'(5);
        gy_v[0 +: NB] = NB'(-3);
        applyStimulus(4'b0001, gx_v, gy_v);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, gx_v, gy_v);

        // Pointer at 1: grant 1 (pointer moves to 2), then 0011 wraps to 0.
        for (int k = 0; k < N; k++) begin
            gx_v[k*NB +: NB] = NB'(20 + k);
            gy_v[k*NB +: NB] = NB'(-(40 + 3 * k));
        end
        applyStimulus(4'b0010, gx_v, gy_v);
        applyStimulus(4'b0011, gx_v, gy_v);
        applyStimulus(4'b0010, gx_v, gy_v);
        applyStimulus(4'b1000, gx_v, gy_v);

        // All four requesters valid for eight cycles, starting from pointer 0.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) begin
                gx_v[k*NB +: NB] = NB'(i * 16 + k * 3 + 1);
                gy_v[k*NB +: NB] = NB'(-(i * 8 + k * 5 + 2));
            end
            applyStimulus(4'b1111, gx_v, gy_v);
        end

        // Idle cycles with changing data: nothing may move.
        for (int i = 0; i < 4; i++) begin
            gx_v = {N{NB'(100 + i)}};
            gy_v = {N{NB'(-(200 + i))}};
            applyStimulus(4'b0000, gx_v, gy_v);
        end

        // Reset with two requests in flight, then grant on the first edge.
        applyStimulus(4'b0011, gx_v, gy_v);
        applyStimulus(4'b0010, gx_v, gy_v);
        resetPulse(4'b0011);
        gx_v[2*NB +: NB] = NB'(-7);
        gy_v[2*NB +: NB] = NB'(9);
        applyStimulus(4'b0100, gx_v, gy_v);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, gx_v, gy_v);

`ifdef ATAN_ARB_STATS_EN
        // Saturate requester 1's counter; the other counters keep their counts.
        for (int i = 0; i < 70000; i++) applyStimulus(4'b0010, gx_v, gy_v);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, gx_v, gy_v);
        checkOutput("cnt1_sat", 64'(o_grant_cnt[1*16 +: 16]), 64'(16'hFFFF));
        for (int k = 0; k < N; k++) begin
            checkOutput("grant_cnt", 64'(o_grant_cnt[k*16 +: 16]), 64'(m_cnt[k]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
